// File: rtl/tone_generator_pkg.sv
// Shared audio constants for the tone generator and its neighbours.
package tone_generator_pkg;

    localparam int unsigned CLK_HZ_DEFAULT        = 125_000_000;
    localparam int unsigned FREQ_W                = 24;
    localparam int unsigned ACC_W_DEFAULT         = 32;
    localparam int unsigned LOW_DUTY_BITS_DEFAULT = 3;

endpackage

// File: rtl/tone_generator.sv
// Square-wave tone source for the PWM audio output.
// A fractional (Bresenham) accumulator toggles the wave 2*freq times per
// second, giving an exact long-term frequency of freq Hz with no divider.
// Low volume gates the high phase with a 1/2^LOW_DUTY_BITS duty PWM.
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   output_enable   1 = tone active, 0 = output low and generator cleared
//   freq            tone frequency in Hz (0 = silence)
//   volume          1 = full amplitude, 0 = PWM-gated high phase
//   square_wave_out registered 1-bit audio output
module tone_generator
    import tone_generator_pkg::*;
#(
    parameter int unsigned CLK_HZ        = CLK_HZ_DEFAULT,
    parameter int unsigned ACC_W         = ACC_W_DEFAULT,
    parameter int unsigned LOW_DUTY_BITS = LOW_DUTY_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              output_enable,
    input  logic [FREQ_W-1:0] freq,
    input  logic              volume,
    output logic              square_wave_out
);

    logic [ACC_W-1:0]         r_acc;
    logic                     r_wave;
    logic [LOW_DUTY_BITS-1:0] r_pwm_cnt;

    logic                     w_active;
    logic [ACC_W-1:0]         w_sum;
    logic                     w_wrap;
    logic                     w_gate;

    // Increment is 2*freq so the wave toggles twice per output period.
    always_comb begin
        w_active = output_enable & (freq != '0);
        w_sum    = r_acc + ACC_W'({freq, 1'b0});
        w_wrap   = (w_sum >= ACC_W'(CLK_HZ));
        w_gate   = volume | (r_pwm_cnt == '0);
    end

    // Accumulator, wave phase, free-running PWM counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc           <= '0;
            r_wave          <= 1'b0;
            r_pwm_cnt       <= '0;
            square_wave_out <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + LOW_DUTY_BITS'(1);
            if (w_active) begin
                // 2*freq < CLK_HZ, so a single subtraction keeps acc < CLK_HZ.
                r_acc <= w_wrap ? (w_sum - ACC_W'(CLK_HZ)) : w_sum;
                if (w_wrap) begin
                    r_wave <= ~r_wave;
                end
                square_wave_out <= r_wave & w_gate;
            end else begin
                r_acc           <= '0;
                r_wave          <= 1'b0;
                square_wave_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator at the default 125 MHz clock, using
// high tone frequencies so each scenario spans only a few hundred clocks.
module tb_tone_generator;
    import tone_generator_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              output_enable;
    logic [FREQ_W-1:0] freq;
    logic              volume;
    logic              square_wave_out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int unsigned base  = 0;
    int unsigned acc_max = 0;
    logic        prev  = 1'b0;
    int unsigned trans[$];
    int unsigned highs[$];

    tone_generator #(
        .CLK_HZ       (125_000_000),
        .ACC_W        (32),
        .LOW_DUTY_BITS(3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .output_enable  (output_enable),
        .freq           (freq),
        .volume         (volume),
        .square_wave_out(square_wave_out)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record output transitions and high samples, relative to base.
    always @(negedge clk) begin
        if (square_wave_out !== prev) trans.push_back(cyc - base);
        if (square_wave_out === 1'b1) highs.push_back(cyc - base);
        if (dut.r_acc > acc_max) acc_max = dut.r_acc;
        prev = square_wave_out;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic start_window();
        base = cyc;
        trans.delete();
        highs.delete();
    endtask

    task automatic wait_high(input string tag, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (square_wave_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            run(1);
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    function automatic int unsigned gaps_outside(input int unsigned lo, input int unsigned hi);
        int unsigned bad = 0;
        for (int i = 1; i < trans.size(); i++) begin
            if ((trans[i] - trans[i-1]) < lo || (trans[i] - trans[i-1]) > hi) bad++;
        end
        return bad;
    endfunction

    function automatic int unsigned gaps_equal(input int unsigned v);
        int unsigned n = 0;
        for (int i = 1; i < trans.size(); i++) begin
            if ((trans[i] - trans[i-1]) == v) n++;
        end
        return n;
    endfunction

    initial begin
        int unsigned bad;

        rst = 1'b1; output_enable = 1'b1; freq = 24'd2_500_000; volume = 1'b1;
        run(3);
        check_eq("reset_out", 32'(square_wave_out), 32'd0);

        // Idle: disabled with freq 0, then disabled with a nonzero freq.
        rst = 1'b0; output_enable = 1'b0; freq = '0;
        start_window();
        run(200);
        check_eq("idle_off_highs", highs.size(), 32'd0);
        freq = 24'd2_500_000;
        start_window();
        run(100);
        check_eq("idle_dis_highs", highs.size(), 32'd0);

        // 2.5 MHz: exactly 25-clock half periods, first output edge at 26.
        output_enable = 1'b1;
        start_window();
        run(500);
        check_eq("f25_first", trans.size() > 0 ? trans[0] : 0, 32'd26);
        check_eq("f25_count", trans.size(), 32'd19);
        check_eq("f25_gaps", gaps_outside(25, 25), 32'd0);

        // Low volume: highs only in wave-high phases, spaced by multiples of 8.
        volume = 1'b0;
        highs.delete();
        run(410);
        bad = 0;
        for (int i = 0; i < highs.size(); i++) begin
            if ((((highs[i] - 1) / 25) % 2) != 1) bad++;
        end
        check_eq("lowvol_envelope", bad, 32'd0);
        bad = 0;
        for (int i = 1; i < highs.size(); i++) begin
            if (((highs[i] - highs[i-1]) % 8) != 0) bad++;
        end
        check_eq("lowvol_spacing", bad, 32'd0);
        check_eq("lowvol_cnt_rng", 32'(highs.size() >= 20 && highs.size() <= 30), 32'd1);

        // Back to full volume: phase grid unchanged.
        volume = 1'b1;
        trans.delete();
        run(200);
        check_eq("vol1_first", trans.size() > 0 ? trans[0] : 0, 32'd926);
        check_eq("vol1_count", trans.size(), 32'd8);
        check_eq("vol1_gaps", gaps_outside(25, 25), 32'd0);

        // freq 0 while the output is high silences within one clock.
        wait_high("wait_high_a", 100);
        freq = '0; volume = 1'b0;
        run(1);
        check_eq("silence_1clk", 32'(square_wave_out), 32'd0);
        start_window();
        run(200);
        check_eq("silence_highs", highs.size(), 32'd0);

        // 1 MHz: 62.5-clock half periods alternate 62/63, first edge at 64.
        freq = 24'd1_000_000; volume = 1'b1;
        start_window();
        run(1000);
        check_eq("f1m_first", trans.size() > 0 ? trans[0] : 0, 32'd64);
        check_eq("f1m_count", trans.size(), 32'd15);
        check_eq("f1m_gaps", gaps_outside(62, 63), 32'd0);
        check_eq("f1m_gap62", gaps_equal(62), 32'd7);

        // Reset mid-tone clears output on that edge and restarts phase.
        wait_high("wait_high_b", 200);
        rst = 1'b1; freq = 24'd2_500_000;
        run(1);
        check_eq("rst_mid_out", 32'(square_wave_out), 32'd0);
        run(1);
        rst = 1'b0;
        start_window();
        run(100);
        check_eq("rst_first", trans.size() > 0 ? trans[0] : 0, 32'd26);
        check_eq("rst_count", trans.size(), 32'd3);

        // Maximum frequency: 3/4-clock half periods, acc stays below CLK_HZ.
        output_enable = 1'b0;
        run(2);
        output_enable = 1'b1; freq = 24'hFFFFFF;
        acc_max = 0;
        start_window();
        run(1000);
        check_eq("fmax_first", trans.size() > 0 ? trans[0] : 0, 32'd5);
        check_eq("fmax_count", trans.size(), 32'd268);
        check_eq("fmax_gaps", gaps_outside(3, 4), 32'd0);
        check_eq("fmax_acc_lt_clk", 32'(acc_max < 125_000_000), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
